hazard_ctrl: RTL and testbench

//  Pipeline hazard controller, the companion of the forwarding unit. It resolves

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// Handles the hazards that forwarding cannot resolve: load-use stalls,
// taken-branch flushes, and multi-cycle data-memory waits. A watchdog on the
// memory wait raises a sticky error. Saturating counters record stall cycles
// and accepted branch flushes.
module hazard_ctrl #(
  parameter int REG_SELECT  = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_SELECT-1:0] i_reg_a_select_D,
  input  logic [REG_SELECT-1:0] i_reg_b_select_D,
  input  logic                  i_uses_b_D,
  input  logic                  i_is_load_E,
  input  logic [REG_SELECT-1:0] i_reg_c_select_E,
  input  logic                  i_branch_taken_E,
  input  logic                  i_mem_req_M,
  input  logic                  i_mem_ready_M,
  output logic                  o_stall_F,
  output logic                  o_stall_D,
  output logic                  o_flush_D,
  output logic                  o_bubble_E,
  output logic                  o_stall_E,
  output logic                  o_bubble_W,
  output logic                  o_mem_err,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  // Last wait count before the watchdog fires on the next not-ready edge.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t                state_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic                  mem_err_q;
  logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0]  flush_count_q,  flush_count_d;

  logic mem_busy;
  logic load_use;
  logic mem_stall;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 en);
    logic [CNT_WIDTH-1:0] r;
    r = v;
    if (en && (v != {CNT_WIDTH{1'b1}})) r = v + CNT_WIDTH'(1);
    return r;
  endfunction

  assign mem_busy = i_mem_req_M & ~i_mem_ready_M;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = i_is_load_E && (i_reg_c_select_E != '0) &&
                    ((i_reg_c_select_E == i_reg_a_select_D) ||
                     (i_uses_b_D && (i_reg_c_select_E == i_reg_b_select_D)));

  // In MEM_WAIT the request line is irrelevant; only ready releases the stall.
  assign mem_stall = (state_q == ST_ERR) ||
                     ((state_q == ST_MEM_WAIT) && !i_mem_ready_M) ||
                     ((state_q == ST_RUN) && mem_busy);

  // Zero-latency pipeline control; memory stall masks branch and load-use so
  // they are re-evaluated once the pipeline moves again.
  always_comb begin
    o_stall_F  = 1'b0;
    o_stall_D  = 1'b0;
    o_flush_D  = 1'b0;
    o_bubble_E = 1'b0;
    o_stall_E  = 1'b0;
    o_bubble_W = 1'b0;
    if (!i_rst) begin
      if (mem_stall) begin
        o_stall_F  = 1'b1;
        o_stall_D  = 1'b1;
        o_stall_E  = 1'b1;
        o_bubble_W = 1'b1;
      end else if (i_branch_taken_E) begin
        // Decode instruction is on the wrong path, so load-use is moot.
        o_flush_D  = 1'b1;
        o_bubble_E = 1'b1;
      end else if (load_use) begin
        o_stall_F  = 1'b1;
        o_stall_D  = 1'b1;
        o_bubble_E = 1'b1;
      end
    end
  end

  // Memory-wait FSM with watchdog; ERR is left only through reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ready_M) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= ST_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_ONE;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Next values of the saturating perf counters.
  always_comb begin
    stall_cycles_d = sat_inc(stall_cycles_q, o_stall_F);
    flush_count_d  = sat_inc(flush_count_q,  o_flush_D);
  end

  // Perf counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign o_mem_err      = mem_err_q;
  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic,
// with a reference model feeding an expectation queue and a monitor checking.
module tb_hazard_ctrl;

  localparam int RS  = 5;
  localparam int CW  = 4;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RS-1:0] a_D = '0, b_D = '0, c_E = '0;
  logic          ub_D = 1'b0, ld_E = 1'b0, br_E = 1'b0, req_M = 1'b0, rdy_M = 1'b0;
  logic          stall_F, stall_D, flush_D, bubble_E, stall_E, bubble_W, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.REG_SELECT(RS), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_a_select_D(a_D), .i_reg_b_select_D(b_D), .i_uses_b_D(ub_D),
    .i_is_load_E(ld_E), .i_reg_c_select_E(c_E), .i_branch_taken_E(br_E),
    .i_mem_req_M(req_M), .i_mem_ready_M(rdy_M),
    .o_stall_F(stall_F), .o_stall_D(stall_D), .o_flush_D(flush_D),
    .o_bubble_E(bubble_E), .o_stall_E(stall_E), .o_bubble_W(bubble_W),
    .o_mem_err(mem_err), .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sF, sD, fD, bE, sE, bW, err;
    int   sc, fc;
    int   id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;

  // Abstract model state: waiting on memory, how many not-ready edges so far,
  // error latched, and the two event tallies.
  bit m_wait = 0;
  int m_edges = 0;
  bit m_err = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (cycle #%0d): got %0h, expected %0h", name, id, act, req);
    end
  endtask

  // One cycle of stimulus: drive, predict, enqueue, advance model across the edge.
  task automatic cyc(input bit r, input int a, input int b, input bit ub, input bit ld,
                     input int c, input bit br, input bit rq, input bit rd, input bit check = 1);
    exp_t e;
    bit busy, lu;
    @(negedge clk);
    rst = r; a_D = RS'(a); b_D = RS'(b); ub_D = ub; ld_E = ld; c_E = RS'(c);
    br_E = br; req_M = rq; rdy_M = rd;
    busy = rq && !rd;
    lu   = ld && (c != 0) && ((c == a) || (ub && (c == b)));
    e.sF = 0; e.sD = 0; e.fD = 0; e.bE = 0; e.sE = 0; e.bW = 0;
    e.err = m_err; e.sc = m_sc; e.fc = m_fc; e.id = n_issued;
    if (!r) begin
      if (m_err || (m_wait && !rd) || (!m_wait && busy)) begin
        e.sF = 1; e.sD = 1; e.sE = 1; e.bW = 1;
      end else if (br) begin
        e.fD = 1; e.bE = 1;
      end else if (lu) begin
        e.sF = 1; e.sD = 1; e.bE = 1;
      end
    end
    if (check) begin
      exp_q.push_back(e);
      n_issued++;
    end
    if (r) begin
      m_wait = 0; m_edges = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.sF && m_sc < SAT) m_sc++;
      if (e.fD && m_fc < SAT) m_fc++;
      if (!m_err) begin
        if (m_wait) begin
          if (rd) begin
            m_wait = 0; m_edges = 0;
          end else begin
            m_edges++;
            if (m_edges >= TO) m_err = 1;
          end
        end else if (busy) begin
          m_wait = 1; m_edges = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle, so each settled cycle pops one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_F",      e.id, 16'(stall_F),      16'(e.sF));
        chk("stall_D",      e.id, 16'(stall_D),      16'(e.sD));
        chk("flush_D",      e.id, 16'(flush_D),      16'(e.fD));
        chk("bubble_E",     e.id, 16'(bubble_E),     16'(e.bE));
        chk("stall_E",      e.id, 16'(stall_E),      16'(e.sE));
        chk("bubble_W",     e.id, 16'(bubble_W),     16'(e.bW));
        chk("mem_err",      e.id, 16'(mem_err),      16'(e.err));
        chk("stall_cycles", e.id, 16'(stall_cycles), 16'(e.sc));
        chk("flush_count",  e.id, 16'(flush_count),  16'(e.fc));
      end
    end
  end

  initial begin
    // Reset: first cycle unchecked (registers still unknown), second checked.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Load-use on source A, then cleared; c_E=0 never stalls.
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Source B gated by uses_b.
    cyc(0, 1, 7, 0, 1, 7, 0, 0, 0);
    cyc(0, 1, 7, 1, 1, 7, 0, 0, 0);
    idle(1);
    // Branch wins over load-use.
    cyc(0, 5, 0, 0, 1, 5, 1, 0, 0);
    idle(1);
    // Three busy cycles then ready; branch held behind the memory stall.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Watchdog: busy held until error, stalls persist, ready ignored in ERR.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    // Saturation: keep stalling in ERR well past 15 cycles.
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Saturation through load-use stalls.
    for (int i = 0; i < 20; i++) cyc(0, 3, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(39) == 0),
          int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)),
          1'($urandom_range(1)), int'($urandom_range(3)),
          ($urandom_range(4) == 0),
          ($urandom_range(3) == 0), 1'($urandom_range(1)));
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
